// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the pipeline stages: instruction codes,
// register IDs and status codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // RNONE on either side means "no register", so it can never forward.
  function automatic logic id_match(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Y86-64 register file: two combinational read ports, two clocked write
// ports (port M has priority on a shared destination), asynchronous clear.
module regfile
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  input  logic [3:0]       dst_e,
  input  logic [WIDTH-1:0] val_e,
  input  logic [3:0]       dst_m,
  input  logic [WIDTH-1:0] val_m
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    // NOTE: start from the held value so every path assigns regs_d; no latch.
    regs_d = regs_q;
    if (dst_e != RNONE) regs_d[dst_e] = val_e;
    // Applied after port E so popq %rsp leaves the popped value in %rsp.
    if (dst_m != RNONE) regs_d[dst_m] = val_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is architectural state that must read 0 after reset,
      // so it is cleared here; pure storage RAMs normally are not reset.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      regs_q <= regs_d;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register with stall/bubble, register ID
// decode, register file and the valA/valB forwarding muxes.
module decode_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic [2:0]       f_stat,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [WIDTH-1:0] f_valC,
  input  logic [WIDTH-1:0] f_valP,
  input  logic [3:0]       e_dstE,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [3:0]       M_dstE,
  input  logic [WIDTH-1:0] M_valE,
  input  logic [3:0]       M_dstM,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [3:0]       W_dstE,
  input  logic [WIDTH-1:0] W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [WIDTH-1:0] W_valM,
  output logic [2:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [WIDTH-1:0] D_valC,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic [3:0]       d_dstE,
  output logic [3:0]       d_dstM,
  output logic [WIDTH-1:0] d_valA,
  output logic [WIDTH-1:0] d_valB
);

  typedef struct packed {
    logic [2:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [WIDTH-1:0] valc;
    logic [WIDTH-1:0] valp;
  } d_reg_t;

  localparam d_reg_t BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0, ra: RNONE,
                                rb: RNONE, valc: '0, valp: '0};

  d_reg_t d_reg_q, d_reg_d;
  logic [WIDTH-1:0] rf_val_a, rf_val_b;

  // Stall outranks bubble so a both-asserted cycle holds the instruction.
  always_comb begin
    d_reg_d = d_reg_q;
    if (!D_stall) begin
      if (D_bubble) d_reg_d = BUBBLE;
      else          d_reg_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA,
                                rb: f_rB, valc: f_valC, valp: f_valP};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_reg_q <= BUBBLE;
    else     d_reg_q <= d_reg_d;
  end

  assign D_stat  = d_reg_q.stat;
  assign D_icode = d_reg_q.icode;
  assign D_ifun  = d_reg_q.ifun;
  assign D_valC  = d_reg_q.valc;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (d_reg_q.icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d_srcA = d_reg_q.ra;
      IRET, IPOPQ:                    d_srcA = RSP;
      default:                        d_srcA = RNONE;
    endcase
    case (d_reg_q.icode)
      IRMMOVQ, IMRMOVQ, IOPQ:     d_srcB = d_reg_q.rb;
      ICALL, IRET, IPUSHQ, IPOPQ: d_srcB = RSP;
      default:                    d_srcB = RNONE;
    endcase
    case (d_reg_q.icode)
      IRRMOVQ, IIRMOVQ, IOPQ:     d_dstE = d_reg_q.rb;
      ICALL, IRET, IPUSHQ, IPOPQ: d_dstE = RSP;
      default:                    d_dstE = RNONE;
    endcase
    case (d_reg_q.icode)
      IMRMOVQ, IPOPQ: d_dstM = d_reg_q.ra;
      default:        d_dstM = RNONE;
    endcase
  end

  regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (rf_val_a),
    .val_b (rf_val_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );

  // Youngest producer first; jXX and call carry valP down the valA path.
  always_comb begin
    if (d_reg_q.icode == IJXX || d_reg_q.icode == ICALL) d_valA = d_reg_q.valp;
    else if (id_match(d_srcA, e_dstE))                   d_valA = e_valE;
    else if (id_match(d_srcA, M_dstM))                   d_valA = m_valM;
    else if (id_match(d_srcA, M_dstE))                   d_valA = M_valE;
    else if (id_match(d_srcA, W_dstM))                   d_valA = W_valM;
    else if (id_match(d_srcA, W_dstE))                   d_valA = W_valE;
    else                                                 d_valA = rf_val_a;
  end

  always_comb begin
    if      (id_match(d_srcB, e_dstE)) d_valB = e_valE;
    else if (id_match(d_srcB, M_dstM)) d_valB = m_valM;
    else if (id_match(d_srcB, M_dstE)) d_valB = M_valE;
    else if (id_match(d_srcB, W_dstM)) d_valB = W_valM;
    else if (id_match(d_srcB, W_dstE)) d_valB = W_valE;
    else                               d_valB = rf_val_b;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the pipelined Y86-64 processor, directly downstream of fetch. Captures the fetch outputs in the D pipeline register, with stall and bubble control. Decodes source and destination register IDs and holds the 15-entry register file, written from the W stage. Produces forwarded operands d_valA and d_valB for the E pipeline register.

## Interface
- WIDTH, 64: data/address width
- NREG, 15: architectural registers; ID 4'hF = RNONE
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- D_stall, D_bubble  in  1 each  pipeline control from hazard unit
- f_stat  in  3  fetch status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields
- f_valC, f_valP  in  WIDTH each  constant word, incremented PC
- e_dstE/e_valE, M_dstE/M_valE, M_dstM/m_valM, W_dstE/W_valE, W_dstM/W_valM  in  4/WIDTH  forwarding sources
- D_stat  out  3  registered status
- D_icode, D_ifun  out  4 each  registered fields
- D_valC  out  WIDTH  registered constant
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs
- d_valA, d_valB  out  WIDTH  forwarded operands

## Operation
- D register fields: stat, icode, ifun, rA, rB, valC, valP.
- Bubble value: stat=1, icode=1 (nop), ifun=0, rA=rB=F, valC=valP=0.
- srcA:
  - rA for icode 2, 4, 6, A.
  - RSP (4) for icode 9, B.
  - Otherwise F.
- srcB:
  - rB for icode 4, 5, 6.
  - RSP for icode 8, 9, A, B.
  - Otherwise F.
- dstE:
  - rB for icode 2, 3, 6.
  - RSP for icode 8, 9, A, B.
  - Otherwise F.
- dstM: rA for icode 5, B; otherwise F.
- d_valA priority, first match wins:
  1. D_valP if icode is 7 or 8.
  2. e_valE if d_srcA == e_dstE.
  3. m_valM if d_srcA == M_dstM.
  4. M_valE if d_srcA == M_dstE.
  5. W_valM if d_srcA == W_dstM.
  6. W_valE if d_srcA == W_dstE.
  7. Otherwise regfile[d_srcA].
- d_valB uses the same chain without step 1.
- A source or destination ID of F never matches anything.
- A read of ID F returns 0.
- Register file write port E: W_valE is written to W_dstE.
- Register file write port M: W_valM is written to W_dstM.
- If W_dstE == W_dstM and neither is F, port M wins (popq %rsp semantics).
- ID F writes are ignored.
- Unknown icode: all IDs decode to F; D_stat passes through unchanged.

## Timing
- D register updates on posedge clk:
  - D_stall=1: hold all fields.
  - Else D_bubble=1: load the bubble value.
  - Else: load the f_* inputs.
- D_stall and D_bubble both high: stall wins.
- Register file writes on posedge clk. Decode reads are combinational, so a W-stage value is reached by forwarding in the same cycle and read from the file in the next cycle.
- All d_* outputs are combinational from D register, regfile and forwarding inputs; zero added latency.
- Reset, asynchronous and legal mid-operation:
  - D register is forced to the bubble value immediately.
  - All 15 registers clear to 0.
  - Outputs after reset: D_stat=1, D_icode=1, D_ifun=0, D_valC=0, d_src*/d_dst*=F, d_valA=d_valB=0.
- First clock edge after rst deasserts captures f_* normally, subject to stall/bubble.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - Register constants: RSP=4, RNONE=F.
  - stat codes: SAOK=1, SHLT=2, SADR=3, SINS=4.
- One natural sub-module: `regfile`, with two combinational read ports, two synchronous write ports and asynchronous clear.
- D register, ID decode and forwarding muxes stay in `decode_stage`.

## Test plan
- Reset and write: pulse rst mid-run, then write W_dstE=3 with W_valE=0x19.
  - During reset: D_icode=1 and d_valA=0 immediately, without waiting for a clock edge.
  - Next cycle, OPq rA=3: d_valA=0x19 read from the file.
- irmovq then OPq: load icode 6, rA=6, rB=7, with e_dstE=7, e_valE=0x0F and M_dstE=6, M_valE=0x09.
  - Required: d_srcA=6, d_srcB=7, d_valA=0x09, d_valB=0x0F, d_dstE=7.
- Forwarding priority: srcA=2 with e_dstE=2 (value 0xA), M_dstM=2 (0xB) and W_dstE=2 (0xC).
  - Required: d_valA=0xA.
  - Drop e_dstE to F: d_valA=0xB.
- popq %rsp: W_dstE=W_dstM=4, W_valE=0x100, W_valM=0x55.
  - After the edge: regfile[4]=0x55.
- Stall/bubble:
  - D_stall=1 for 2 cycles while f_icode changes: D fields hold.
  - D_bubble=1: D_icode=1, d_dstE=F.
  - Both asserted: hold.
- call: D_icode=8, D_valP=0x4B, d_srcB=4, regfile[4]=0x200.
  - Required: d_valA=0x4B, d_valB=0x200, d_dstE=4.
